// File: rtl/fp_div_if.sv
// Handshake/operand bundle for the fp_div iterative divider.
// Optional o_flags exists only when FP_DIV_FLAGS_EN is defined.
interface fp_div_if #(
    parameter int D_LEN = 32
);
    logic             i_start;
    logic [D_LEN-1:0] i_a;
    logic [D_LEN-1:0] i_b;
    logic [1:0]       i_round_mode;
    logic [D_LEN-1:0] o_result;
    logic             o_done;
    logic             o_busy;
`ifdef FP_DIV_FLAGS_EN
    logic [4:0]       o_flags;

    modport master (
        output i_start, i_a, i_b, i_round_mode,
        input  o_result, o_done, o_busy, o_flags
    );
    modport slave (
        input  i_start, i_a, i_b, i_round_mode,
        output o_result, o_done, o_busy, o_flags
    );
`else
    modport master (
        output i_start, i_a, i_b, i_round_mode,
        input  o_result, o_done, o_busy
    );
    modport slave (
        input  i_start, i_a, i_b, i_round_mode,
        output o_result, o_done, o_busy
    );
`endif
endinterface

// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit per cycle,
// FTZ/DAZ. Define FP_DIV_FLAGS_EN to add o_flags = {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div #(
    parameter int D_LEN  = 32,
    parameter int Q_BITS = 27
) (
    input logic     clk,
    input logic     rst_n,
    fp_div_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StNorm, StRound, StDone} state_e;

    state_e             r_state;
    logic [D_LEN-1:0]   r_a, r_b, r_result;
    logic [1:0]         r_rm;
    logic               r_sign, r_done, r_busy;
    logic signed [9:0]  r_e;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [26:0]        r_q;
    logic [4:0]         r_cnt;
    logic [22:0]        r_man;
    logic               r_g, r_r, r_s;

    logic [7:0]         w_ea, w_eb;
    logic [22:0]        w_fa, w_fb;
    logic               w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan, w_sign;
    logic               w_special;
    logic [D_LEN-1:0]   w_spec_res, w_round_res;
    logic               w_ge, w_inc, w_grs, w_ovf, w_unf;
    logic [23:0]        w_diff, w_man_sum;
    logic signed [9:0]  w_e_rnd;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);

`ifdef FP_DIV_FLAGS_EN
    logic [4:0] r_flags;
    logic       w_invalid, w_dbz;
    assign bus.o_flags = r_flags;
`endif

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
`ifdef FP_DIV_FLAGS_EN
        w_invalid  = 1'b0;
        w_dbz      = 1'b0;
`endif
        if (w_a_nan) begin
            w_spec_res = r_a | 32'h0040_0000;
`ifdef FP_DIV_FLAGS_EN
            w_invalid  = 1'b1;
`endif
        end else if (w_b_nan) begin
            w_spec_res = r_b | 32'h0040_0000;
`ifdef FP_DIV_FLAGS_EN
            w_invalid  = 1'b1;
`endif
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_spec_res = {w_sign, 8'hFF, 23'h40_0000};
`ifdef FP_DIV_FLAGS_EN
            w_invalid  = 1'b1;
`endif
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
            w_dbz      = 1'b1;
`endif
        end else if (w_a_zero || w_b_inf) begin
            w_spec_res = {w_sign, 31'd0};
        end else begin
            w_special  = 1'b0;
        end
    end

    // After a successful subtract the remainder is below Mb, so 24 bits hold it.
    assign w_ge   = (r_rem >= {1'b0, r_mb});
    assign w_diff = r_rem[23:0] - r_mb;

    assign w_grs = r_g | r_r | r_s;
    always_comb begin
        w_inc = 1'b0;
        unique case (r_rm)
            2'b00: w_inc = r_g & (r_r | r_s | r_man[0]);
            2'b01: w_inc = 1'b0;
            2'b10: w_inc = ~r_sign & w_grs;
            2'b11: w_inc = r_sign & w_grs;
        endcase
    end

    // Mantissa carry-out leaves the fraction all-zero, so only the exponent needs bumping.
    assign w_man_sum = {1'b0, r_man} + {23'd0, w_inc};
    assign w_e_rnd   = r_e + $signed({9'd0, w_man_sum[23]});
    assign w_ovf     = (w_e_rnd >= 10'sd255);
    assign w_unf     = (w_e_rnd <= 10'sd0);

    always_comb begin
        if (w_ovf)      w_round_res = {r_sign, 8'hFF, 23'd0};
        else if (w_unf) w_round_res = {r_sign, 31'd0};
        else            w_round_res = {r_sign, w_e_rnd[7:0], w_man_sum[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_rm     <= '0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_e      <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_man    <= '0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
            r_flags  <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_b;
                        r_rm    <= bus.i_round_mode;
                        r_busy  <= 1'b1;
                        r_state <= StUnpack;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StUnpack: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
                        r_flags  <= {w_invalid, w_dbz, 3'b000};
`endif
                        r_state  <= StDone;
                    end else begin
                        r_e     <= $signed({2'b00, w_ea} - {2'b00, w_eb} + 10'd127);
                        r_rem   <= {2'b01, w_fa};
                        r_mb    <= {1'b1, w_fb};
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_state <= StDivide;
                    end
                end
                StDivide: begin
                    r_q   <= {r_q[25:0], w_ge};
                    r_rem <= w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(Q_BITS - 1)) r_state <= StNorm;
                end
                StNorm: begin
                    if (r_q[26]) begin
                        r_man <= r_q[25:3];
                        r_g   <= r_q[2];
                        r_r   <= r_q[1];
                        r_s   <= r_q[0] | (r_rem != 25'd0);
                    end else begin
                        r_e   <= r_e - 10'sd1;
                        r_man <= r_q[24:2];
                        r_g   <= r_q[1];
                        r_r   <= r_q[0];
                        r_s   <= (r_rem != 25'd0);
                    end
                    r_state <= StRound;
                end
                StRound: begin
                    r_result <= w_round_res;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
                    r_flags  <= {2'b00, w_ovf, w_unf & ~w_ovf, w_grs | w_ovf | w_unf};
`endif
                    r_state  <= StDone;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_done   = r_done;
    assign bus.o_busy   = r_busy;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases plus randomized operands against an
// integer-arithmetic reference model of the division and rounding rules.
module tb_fp_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fp_div_if #(.D_LEN(32)) bus ();

    fp_div #(.D_LEN(32), .Q_BITS(27)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: quotient from one wide integer division, then normalize/round by the rules.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm, output bit special);
        bit s, a_z, b_z, a_i, b_i, a_n, b_n, g, r, st, inc;
        int ea, eb, e, mant;
        longint unsigned ma, mb, q, rem;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        a_z = (ea == 0);
        b_z = (eb == 0);
        a_i = (ea == 255) && (a[22:0] == 0);
        b_i = (eb == 255) && (b[22:0] == 0);
        a_n = (ea == 255) && (a[22:0] != 0);
        b_n = (eb == 255) && (b[22:0] != 0);
        special = 1'b1;
        if (a_n) return a | 32'h0040_0000;
        if (b_n) return b | 32'h0040_0000;
        if ((a_i && b_i) || (a_z && b_z)) return {s, 8'hFF, 23'h40_0000};
        if (a_i || b_z) return {s, 8'hFF, 23'd0};
        if (a_z || b_i) return {s, 31'd0};
        special = 1'b0;
        ma  = 64'd8388608 + longint'(a[22:0]);
        mb  = 64'd8388608 + longint'(b[22:0]);
        q   = (ma << 26) / mb;
        rem = (ma << 26) % mb;
        e   = ea - eb + 127;
        if (q >= 64'd67108864) begin
            mant = int'(q >> 3) % 8388608;
            g = q[2]; r = q[1]; st = q[0] | (rem != 0);
        end else begin
            e = e - 1;
            mant = int'(q >> 2) % 8388608;
            g = q[1]; r = q[0]; st = (rem != 0);
        end
        case (rm)
            2'b00:   inc = g & (r | st | mant[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !s & (g | r | st);
            default: inc = s & (g | r | st);
        endcase
        mant = mant + int'(inc);
        if (mant >= 8388608) begin
            mant = mant - 8388608;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            2: v[30:23] = 8'($urandom_range(1, 8));
            3: v[30:23] = 8'($urandom_range(246, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Drives one operation; lat = rising edges from acceptance up to the one at which done is high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input bit poke, output logic [31:0] res, output int lat,
                         output bit busy_bad);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_round_mode = rm;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_a = $urandom;
        bus.i_b = $urandom;
        bus.i_round_mode = 2'($urandom);
        lat = 0;
        busy_bad = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (bus.o_done) begin
                lat = i;
                break;
            end
            if (!bus.o_busy) busy_bad = 1'b1;
            bus.i_start = poke && (i == 5);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        res = bus.o_result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_result !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_result: got %h, required 00000000", bus.o_result);
        end
        n_checks++;
        if (bus.o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b, required 0", bus.o_done);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %b, required 0", bus.o_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat;
        bit bb;
        do_op(32'h40C0_0000, 32'h4000_0000, 2'b00, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== 32'h4040_0000) begin
            n_errors++;
            $display("FAIL basic_6div2: got %h, required 40400000", res);
        end
        n_checks++;
        if (lat != 31) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d, required 31", lat);
        end
        n_checks++;
        if (bb) begin
            n_errors++;
            $display("FAIL basic_busy: busy dropped before done, required high throughout");
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse: got %b one cycle later, required 0", bus.o_done);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] exp_tab [4] = '{32'h3EAA_AAAB, 32'h3EAA_AAAA, 32'h3EAA_AAAB, 32'h3EAA_AAAA};
        logic [31:0] res;
        int lat;
        bit bb;
        for (int m = 0; m < 4; m++) begin
            do_op(32'h3F80_0000, 32'h4040_0000, 2'(m), 1'b0, res, lat, bb);
            n_checks++;
            if (res !== exp_tab[m]) begin
                n_errors++;
                $display("FAIL round_third_mode%0d: got %h, required %h", m, res, exp_tab[m]);
            end
            n_checks++;
            if (lat != 31) begin
                n_errors++;
                $display("FAIL round_latency_mode%0d: got %0d, required 31", m, lat);
            end
        end
    endtask

    task automatic test_special_and_range();
        logic [31:0] ta [7] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0001,
                                32'h7F00_0000, 32'h0080_0000, 32'h0000_0001};
        logic [31:0] tb [7] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000,
                                32'h3E80_0000, 32'h4000_0000, 32'h3F80_0000};
        logic [31:0] te [7] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0001,
                                32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
        int tl [7] = '{2, 2, 2, 2, 31, 31, 2};
        logic [31:0] res;
        int lat;
        bit bb;
        for (int k = 0; k < 7; k++) begin
            do_op(ta[k], tb[k], 2'b00, 1'b0, res, lat, bb);
            n_checks++;
            if (res !== te[k]) begin
                n_errors++;
                $display("FAIL edge_%0d %h/%h: got %h, required %h", k, ta[k], tb[k], res, te[k]);
            end
            n_checks++;
            if (lat != tl[k]) begin
                n_errors++;
                $display("FAIL edge_latency_%0d: got %0d, required %0d", k, lat, tl[k]);
            end
        end
    endtask

    task automatic test_control();
        logic [31:0] res;
        int lat;
        bit bb;
        bit seen;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a = 32'h40C0_0000;
        bus.i_b = 32'h4000_0000;
        bus.i_round_mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_done, bus.o_busy, bus.o_result} !== 34'd0) begin
            n_errors++;
            $display("FAIL midop_reset: got done=%b busy=%b result=%h, required all 0",
                     bus.o_done, bus.o_busy, bus.o_result);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL midop_no_done: got a done pulse, required none after abort");
        end
        do_op(32'h40C0_0000, 32'h4000_0000, 2'b00, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== 32'h4040_0000) begin
            n_errors++;
            $display("FAIL post_reset_op: got %h, required 40400000", res);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, 2'b00, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== 32'h4040_0000 || lat != 31) begin
            n_errors++;
            $display("FAIL start_while_busy: got %h lat %0d, required 40400000 lat 31", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] res1, res2;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a = 32'h3F80_0000;
        bus.i_b = 32'h4040_0000;
        bus.i_round_mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        lat1 = 0;
        res1 = 32'd0;
        for (int i = 1; i <= 100; i++) begin
            if (bus.o_done) begin
                lat1 = i;
                res1 = bus.o_result;
                break;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b1;
        bus.i_a = 32'h40C0_0000;
        bus.i_b = 32'h4000_0000;
        bus.i_round_mode = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        lat2 = 0;
        res2 = 32'd0;
        for (int i = 1; i <= 100; i++) begin
            if (bus.o_done) begin
                lat2 = i;
                res2 = bus.o_result;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (res1 !== 32'h3EAA_AAAB || lat1 != 31) begin
            n_errors++;
            $display("FAIL b2b_first: got %h lat %0d, required 3eaaaaab lat 31", res1, lat1);
        end
        n_checks++;
        if (res2 !== 32'h4040_0000 || lat2 != 31) begin
            n_errors++;
            $display("FAIL b2b_second: got %h lat %0d, required 40400000 lat 31", res2, lat2);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, expv;
        logic [1:0] rm;
        int lat, exp_lat;
        bit bb, sp;
        for (int n = 0; n < 150; n++) begin
            a = rand_operand();
            b = rand_operand();
            rm = 2'($urandom_range(0, 3));
            expv = ref_div(a, b, rm, sp);
            exp_lat = sp ? 2 : 31;
            do_op(a, b, rm, 1'b0, res, lat, bb);
            n_checks++;
            if (res !== expv || lat != exp_lat) begin
                n_errors++;
                $display("FAIL random_%0d %h/%h rm%0d: got %h lat %0d, required %h lat %0d",
                         n, a, b, rm, res, lat, expv, exp_lat);
            end
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_round_mode = 2'b00;
        test_reset();
        test_basic();
        test_rounding();
        test_special_and_range();
        test_control();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
